// File: rtl/cbus_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : cbus_mem_responder_if
// Brief    : Cache-bus request/response bundle between a master and a memory
//            responder.
// Revision : 1.0
// ============================================================================
interface cbus_mem_responder_if;
    // request, master -> worker
    logic        req_valid;
    logic        req_is_write;
    logic [2:0]  req_size;      // bytes per beat = 1 << size
    logic [63:0] req_addr;
    logic [7:0]  req_strobe;
    logic [63:0] req_data;
    logic [7:0]  req_len;       // beats - 1
    logic [1:0]  req_burst;     // 0 FIXED, 1 INCR, 2 WRAP, 3 reserved (INCR)
    // response, worker -> master
    logic        resp_ready;
    logic        resp_last;
    logic [63:0] resp_data;

    modport master (
        output req_valid, req_is_write, req_size, req_addr, req_strobe,
               req_data, req_len, req_burst,
        input  resp_ready, resp_last, resp_data
    );

    modport slave (
        input  req_valid, req_is_write, req_size, req_addr, req_strobe,
               req_data, req_len, req_burst,
        output resp_ready, resp_last, resp_data
    );
endinterface
`default_nettype wire

// File: rtl/cbus_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : cbus_mem_responder
// Brief    : Cache-bus memory worker serving single/burst reads and writes
//            (FIXED/INCR/WRAP) from an internal 64-bit word array.
//            Optional macro CBUS_RESP_WAIT_EN adds a WAIT_CYCLES stall state.
// Revision : 1.0
// ============================================================================
module cbus_mem_responder #(
    parameter int unsigned MEM_WORDS   = 4096,
    parameter logic [63:0] BASE_ADDR   = 64'h00000000_80000000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    cbus_mem_responder_if.slave   cbus
);

    localparam int unsigned c_AW    = $clog2(MEM_WORDS);
    localparam logic [1:0]  c_IDLE  = 2'd0;
    localparam logic [1:0]  c_WAIT  = 2'd1;
    localparam logic [1:0]  c_BURST = 2'd2;
    localparam logic [1:0]  c_DONE  = 2'd3;
    localparam logic [1:0]  c_FIXED = 2'd0;
    localparam logic [1:0]  c_WRAP  = 2'd2;
`ifdef CBUS_RESP_WAIT_EN
    localparam bit          c_WAIT_EN = 1'b1;
`else
    localparam bit          c_WAIT_EN = 1'b0;
`endif

    logic [1:0]      r_state;
    logic [1:0]      w_next;
    logic [63:0]     r_addr;
    logic [2:0]      r_size;
    logic [7:0]      r_len;
    logic [1:0]      r_burst;
    logic            r_is_write;
    logic [7:0]      r_beat;
`ifdef CBUS_RESP_WAIT_EN
    logic [15:0]     r_wait_cnt;
`endif
    logic [63:0]     r_mem [MEM_WORDS];

    logic            w_ready;
    logic            w_last;
    logic [63:0]     w_step_off;
    logic [63:0]     w_incr;
    logic [63:0]     w_mask;
    logic [63:0]     w_baddr;
    logic [c_AW-1:0] w_idx;

    always_ff @(posedge clk) begin
        if (reset) r_state <= c_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (cbus.req_valid)
                    w_next = (c_WAIT_EN && (WAIT_CYCLES > 0)) ? c_WAIT : c_BURST;
            end
            c_WAIT: begin
`ifdef CBUS_RESP_WAIT_EN
                if (!cbus.req_valid)      w_next = c_IDLE;
                else if (r_wait_cnt == 0) w_next = c_BURST;
`else
                w_next = c_IDLE;
`endif
            end
            c_BURST: begin
                if (!cbus.req_valid) w_next = c_IDLE;
                else if (w_last)     w_next = c_DONE;
            end
            default: w_next = c_IDLE;
        endcase
    end

    // Ready is dropped combinationally on reset or a withdrawn valid so an
    // aborted beat never commits a write.
    always_comb begin
        w_ready         = !reset && (r_state == c_BURST) && cbus.req_valid;
        w_last          = w_ready && (r_beat == r_len);
        cbus.resp_ready = w_ready;
        cbus.resp_last  = w_last;
        cbus.resp_data  = (w_ready && !r_is_write) ? r_mem[w_idx] : 64'd0;
    end

    // WRAP keeps the high address bits and wraps the low bits inside a
    // (len+1)*step block.
    always_comb begin
        w_step_off = {56'd0, r_beat} << r_size;
        w_incr     = r_addr + w_step_off;
        w_mask     = (({56'd0, r_len} + 64'd1) << r_size) - 64'd1;
        case (r_burst)
            c_FIXED: w_baddr = r_addr;
            c_WRAP:  w_baddr = (r_addr & ~w_mask) | (w_incr & w_mask);
            default: w_baddr = w_incr;
        endcase
        w_idx = c_AW'((w_baddr - BASE_ADDR) >> 3);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr     <= 64'd0;
            r_size     <= 3'd0;
            r_len      <= 8'd0;
            r_burst    <= 2'd0;
            r_is_write <= 1'b0;
            r_beat     <= 8'd0;
`ifdef CBUS_RESP_WAIT_EN
            r_wait_cnt <= 16'd0;
`endif
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (cbus.req_valid) begin
                        r_addr     <= cbus.req_addr;
                        r_size     <= cbus.req_size;
                        r_len      <= cbus.req_len;
                        r_burst    <= cbus.req_burst;
                        r_is_write <= cbus.req_is_write;
                        r_beat     <= 8'd0;
`ifdef CBUS_RESP_WAIT_EN
                        r_wait_cnt <= 16'(WAIT_CYCLES - 1);
`endif
                    end
                end
`ifdef CBUS_RESP_WAIT_EN
                c_WAIT: begin
                    if (r_wait_cnt != 0) r_wait_cnt <= r_wait_cnt - 16'd1;
                end
`endif
                c_BURST: begin
                    if (w_ready) r_beat <= r_beat + 8'd1;
                end
                default: ;
            endcase
        end
    end

    // Storage has no reset; committed writes survive a reset.
    always_ff @(posedge clk) begin
        if (w_ready && r_is_write) begin
            for (int k = 0; k < 8; k++) begin
                if (cbus.req_strobe[k])
                    r_mem[w_idx][8*k +: 8] <= cbus.req_data[8*k +: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cbus_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_cbus_mem_responder
// Brief    : Randomized scoreboard bench for cbus_mem_responder against a
//            word-array reference model.
// Revision : 1.0
// ============================================================================
module tb_cbus_mem_responder;

    localparam logic [63:0] c_BASE  = 64'h00000000_80000000;
    localparam int          c_WORDS = 4096;
`ifdef CBUS_RESP_WAIT_EN
    localparam int          c_WAIT  = 2;
`else
    localparam int          c_WAIT  = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cbus_mem_responder_if bus ();

    cbus_mem_responder #(
        .MEM_WORDS   (c_WORDS),
        .BASE_ADDR   (c_BASE),
        .WAIT_CYCLES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .cbus  (bus)
    );

    logic [63:0] m [c_WORDS];
    logic [64:0] exp_q [$];
    logic [63:0] wd [256];
    logic [7:0]  st [256];
    logic [64:0] mon_e;
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] beat_addr(input logic [63:0] addr, input logic [2:0] size,
                                              input logic [7:0] len, input logic [1:0] burst,
                                              input int i);
        longint unsigned step, blk, start;
        step = 64'd1 << size;
        case (burst)
            2'd0: return addr;
            2'd2: begin
                blk   = (64'(len) + 64'd1) * step;
                start = addr - (addr % blk);
                return start + ((addr + 64'(i) * step) % blk);
            end
            default: return addr + 64'(i) * step;
        endcase
    endfunction

    function automatic int word_idx(input logic [63:0] a);
        return int'(((a - c_BASE) >> 3) % c_WORDS);
    endfunction

    always @(negedge clk) begin
        if (bus.resp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ready", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("beat_data", bus.resp_data, mon_e[63:0]);
                check("beat_last", 64'(bus.resp_last), 64'(mon_e[64]));
            end
        end else begin
            check("idle_data", bus.resp_data, 64'd0);
            check("idle_last", 64'(bus.resp_last), 64'd0);
        end
    end

    // abort_after > 0 withdraws valid once that many beats have been served.
    task automatic txn(input bit wr, input logic [2:0] size, input logic [63:0] addr,
                       input logic [7:0] len, input logic [1:0] burst, input int abort_after);
        int nb, ndo, beats, cyc, first, idx;
        nb  = int'(len) + 1;
        ndo = (abort_after > 0 && abort_after < nb) ? abort_after : nb;
        for (int i = 0; i < ndo; i++) begin
            idx = word_idx(beat_addr(addr, size, len, burst, i));
            if (wr) begin
                for (int k = 0; k < 8; k++)
                    if (st[i][k]) m[idx][8*k +: 8] = wd[i][8*k +: 8];
                exp_q.push_back({(i == nb - 1), 64'd0});
            end else begin
                exp_q.push_back({(i == nb - 1), m[idx]});
            end
        end
        bus.req_is_write = wr;
        bus.req_size     = size;
        bus.req_addr     = addr;
        bus.req_len      = len;
        bus.req_burst    = burst;
        bus.req_data     = wd[0];
        bus.req_strobe   = st[0];
        bus.req_valid    = 1'b1;
        beats = 0; cyc = 0; first = -1;
        while (beats < ndo && cyc < 400) begin
            @(negedge clk);
            if (bus.resp_ready === 1'b1) begin
                if (first < 0) first = cyc;
                beats++;
                @(posedge clk); #1;
                if (beats < nb) begin
                    bus.req_data   = wd[beats];
                    bus.req_strobe = st[beats];
                end
                if (beats == ndo && ndo < nb) bus.req_valid = 1'b0;
            end
            cyc++;
        end
        check("first_latency", 64'(first), 64'(1 + c_WAIT));
        check("beat_count", 64'(beats), 64'(ndo));
        if (ndo == nb) begin
            @(negedge clk);
            check("done_ready", 64'(bus.resp_ready), 64'd0);
            @(posedge clk); #1;
            bus.req_valid = 1'b0;
        end else begin
            repeat (2) begin
                @(negedge clk);
                check("abort_ready", 64'(bus.resp_ready), 64'd0);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int len_r, ab;
        logic [2:0]  sz;
        logic [1:0]  bu;
        logic [63:0] ad;
        bit          wr;
        bus.req_valid    = 1'b1;
        bus.req_is_write = 1'b1;
        bus.req_size     = 3'd3;
        bus.req_addr     = c_BASE;
        bus.req_len      = 8'd0;
        bus.req_burst    = 2'd1;
        bus.req_data     = 64'hdead_beef_0000_0001;
        bus.req_strobe   = 8'hff;

        // Reset held 3 cycles with a valid request pending
        repeat (3) begin
            @(negedge clk);
            check("reset_ready", 64'(bus.resp_ready), 64'd0);
            check("reset_last", 64'(bus.resp_last), 64'd0);
            check("reset_data", bus.resp_data, 64'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        wd[0] = 64'hdead_beef_0000_0001; st[0] = 8'hff;
        txn(1'b1, 3'd3, c_BASE, 8'd0, 2'd1, 0);

        // Preload mem[i] = i with 256-beat INCR bursts
        for (int j = 0; j < 16; j++) begin
            for (int i = 0; i < 256; i++) begin
                wd[i] = 64'(j * 256 + i);
                st[i] = 8'hff;
            end
            txn(1'b1, 3'd3, c_BASE + 64'(j * 2048), 8'd255, 2'd1, 0);
        end

        // Write 1..4 then read back
        for (int i = 0; i < 4; i++) begin wd[i] = 64'(i + 1); st[i] = 8'hff; end
        txn(1'b1, 3'd3, c_BASE, 8'd3, 2'd1, 0);
        txn(1'b0, 3'd3, c_BASE, 8'd3, 2'd1, 0);

        // Restore mem[0..7] = i, then WRAP read from 0x80000028
        for (int i = 0; i < 8; i++) begin wd[i] = 64'(i); st[i] = 8'hff; end
        txn(1'b1, 3'd3, c_BASE, 8'd7, 2'd1, 0);
        txn(1'b0, 3'd3, c_BASE + 64'h28, 8'd7, 2'd2, 0);

        // Single byte-strobe write over an all-ones-nibble word
        wd[0] = 64'h1111_1111_1111_1111; st[0] = 8'hff;
        txn(1'b1, 3'd3, c_BASE + 64'h10, 8'd0, 2'd1, 0);
        wd[0] = 64'h00cd0000_00000000; st[0] = 8'b0100_0000;
        txn(1'b1, 3'd3, c_BASE + 64'h10, 8'd0, 2'd1, 0);
        txn(1'b0, 3'd3, c_BASE + 64'h10, 8'd0, 2'd1, 0);

        // Abort an 8-beat write after 2 beats, then read the whole range
        for (int i = 0; i < 8; i++) begin wd[i] = {$urandom, $urandom}; st[i] = 8'hff; end
        txn(1'b1, 3'd3, c_BASE + 64'h100, 8'd7, 2'd1, 2);
        txn(1'b0, 3'd3, c_BASE + 64'h100, 8'd7, 2'd1, 0);

        // FIXED read returns the same word on every beat
        txn(1'b0, 3'd3, c_BASE + 64'h18, 8'd3, 2'd0, 0);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            wr = 1'($urandom);
            sz = 3'($urandom % 4);
            bu = 2'($urandom % 4);
            if (bu == 2'd2) len_r = (1 << ($urandom % 5)) - 1;
            else            len_r = int'($urandom % 16);
            if ($urandom % 8 == 0) ad = {$urandom, $urandom};
            else                   ad = c_BASE + 64'($urandom % 65536);
            ab = (len_r > 0 && $urandom % 6 == 0) ? 1 + int'($urandom % len_r) : 0;
            for (int i = 0; i < 16; i++) begin
                wd[i] = {$urandom, $urandom};
                st[i] = 8'($urandom);
            end
            txn(wr, sz, ad, 8'(len_r), bu, ab);
        end

        repeat (3) @(posedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
